// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: architectural widths, the default bubble
// instruction and small field-extraction helpers for RV64 encodings.
package pipeline_pkg;

    localparam int XLEN       = 64;
    localparam int ILEN       = 32;
    localparam int REG_ADDR_W = 5;

    // addi x0,x0,0 -- the canonical bubble inserted on flush and reset.
    localparam logic [ILEN-1:0] DEFAULT_NOP_INSTR = 32'h00000013;

    function automatic logic [REG_ADDR_W-1:0] rs1_field(input logic [ILEN-1:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] rs2_field(input logic [ILEN-1:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] rd_field(input logic [ILEN-1:0] instr);
        return instr[11:7];
    endfunction

    // {funct7[5], funct3}: enough to pick the ALU operation in decode.
    function automatic logic [3:0] ins_field(input logic [ILEN-1:0] instr);
        return {instr[30], instr[14:12]};
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Signal bundle between the fetch/decode stage and the rest of the core.
//
// Handshake: there is no valid/ready pair here. IF_ID_Valid qualifies the
// IF/ID contents every cycle; Stall and Flush are single-cycle combinational
// pipeline controls seen by the ID/EX register in the same cycle they assert.
// The master drives the fetch data and the downstream hazard information;
// the slave (the stage) drives the PC and the IF/ID view.
interface if_id_stage_if import pipeline_pkg::*; ();

    logic [ILEN-1:0]       Instruction;
    logic                  Branch_Taken;
    logic [XLEN-1:0]       Branch_Target;
    logic                  ID_EX_MemRead;
    logic [REG_ADDR_W-1:0] ID_EX_rd;

    logic [XLEN-1:0]       PC_Out;
    logic [XLEN-1:0]       IF_ID_PC_Out;
    logic [ILEN-1:0]       IF_ID_Instruction;
    logic [REG_ADDR_W-1:0] IF_ID_rs1;
    logic [REG_ADDR_W-1:0] IF_ID_rs2;
    logic [REG_ADDR_W-1:0] IF_ID_rd;
    logic [3:0]            IF_ID_Ins;
    logic                  IF_ID_Valid;
    logic                  Stall;
    logic                  Flush;
    logic [31:0]           Stall_Count;

    modport master (
        output Instruction, Branch_Taken, Branch_Target, ID_EX_MemRead, ID_EX_rd,
        input  PC_Out, IF_ID_PC_Out, IF_ID_Instruction, IF_ID_rs1, IF_ID_rs2,
               IF_ID_rd, IF_ID_Ins, IF_ID_Valid, Stall, Flush, Stall_Count
    );

    modport slave (
        input  Instruction, Branch_Taken, Branch_Target, ID_EX_MemRead, ID_EX_rd,
        output PC_Out, IF_ID_PC_Out, IF_ID_Instruction, IF_ID_rs1, IF_ID_rs2,
               IF_ID_rd, IF_ID_Ins, IF_ID_Valid, Stall, Flush, Stall_Count
    );

endinterface

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: flags when the load in ID/EX writes a register
// that the instruction in IF/ID reads. A taken branch or reset suppresses
// the stall because the IF/ID contents are being discarded anyway.
module hazard_detection_unit import pipeline_pkg::*; (
    input  logic                  reset,
    input  logic                  branch_taken,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  if_id_valid,
    output logic                  hazard,
    output logic                  stall
);

    // x0 is never a real dependency, so a load targeting it cannot hazard.
    assign hazard = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    // Only a real instruction in IF/ID can be held; branch and reset win.
    assign stall = hazard && if_id_valid && !branch_taken && !reset;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register.
// Update priority each clock: reset, then branch redirect (flush), then
// load-use stall (hold), then normal advance by 4.
// Build option: define HAZARD_DETECT_EN to include load-use stall logic and
// the stall counter; without it the stage always advances and Stall/
// Stall_Count read as zero.
module if_id_stage import pipeline_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter logic [ILEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic           clk,
    input  logic           reset,
    if_id_stage_if.slave   bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] if_id_pc_q;
    logic [ILEN-1:0] if_id_instr_q;
    logic            if_id_valid_q;
    logic [31:0]     stall_count_q;
    logic            stall;

    // Branch targets are forced word-aligned, so the low bits never matter.
    logic unused_target_bits;
    assign unused_target_bits = ^bus.Branch_Target[1:0];

`ifdef HAZARD_DETECT_EN
    logic unused_hazard;

    hazard_detection_unit u_hazard_detection_unit (
        .reset          (reset),
        .branch_taken   (bus.Branch_Taken),
        .id_ex_mem_read (bus.ID_EX_MemRead),
        .id_ex_rd       (bus.ID_EX_rd),
        .if_id_rs1      (rs1_field(if_id_instr_q)),
        .if_id_rs2      (rs2_field(if_id_instr_q)),
        .if_id_valid    (if_id_valid_q),
        .hazard         (unused_hazard),
        .stall          (stall)
    );

    // Count stall cycles, saturating so the counter never wraps to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end
`else
    // Without hazard detection the compiler guarantees no load-use pairs.
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{bus.ID_EX_MemRead, bus.ID_EX_rd};
    assign stall         = 1'b0;
    assign stall_count_q = '0;
`endif

    // PC and IF/ID register update with reset > redirect > stall > advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else if (bus.Branch_Taken) begin
            pc_q          <= {bus.Branch_Target[XLEN-1:2], 2'b00};
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else if (!stall) begin
            pc_q          <= pc_q + 64'd4;
            if_id_instr_q <= bus.Instruction;
            if_id_pc_q    <= pc_q;
            if_id_valid_q <= 1'b1;
        end
    end

    assign bus.PC_Out            = pc_q;
    assign bus.IF_ID_PC_Out      = if_id_pc_q;
    assign bus.IF_ID_Instruction = if_id_instr_q;
    assign bus.IF_ID_rs1         = rs1_field(if_id_instr_q);
    assign bus.IF_ID_rs2         = rs2_field(if_id_instr_q);
    assign bus.IF_ID_rd          = rd_field(if_id_instr_q);
    assign bus.IF_ID_Ins         = ins_field(if_id_instr_q);
    assign bus.IF_ID_Valid       = if_id_valid_q;
    assign bus.Stall             = stall;
    assign bus.Flush             = bus.Branch_Taken;
    assign bus.Stall_Count       = stall_count_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the
// fetch stage. Follows whichever HAZARD_DETECT_EN setting the RTL is built with.
module tb_if_id_stage;

`ifdef HAZARD_DETECT_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h00000013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_stage_if bus ();

    if_id_stage #(
        .RESET_PC  (64'h0),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid;
    bit          m_known = 1'b0;

    // Load-use rule: a load writing a nonzero register read by a valid IF/ID instruction.
    function automatic logic model_stall();
        logic [4:0] s1, s2;
        s1 = m_instr[19:15];
        s2 = m_instr[24:20];
        return HAZ && m_valid && bus.ID_EX_MemRead && (bus.ID_EX_rd != 5'd0) &&
               (bus.ID_EX_rd == s1 || bus.ID_EX_rd == s2) &&
               !bus.Branch_Taken && !reset;
    endfunction

    always @(posedge clk) begin
        logic st;
        st = model_stall();
        if (reset) begin
            m_pc = 64'h0; m_instr = NOP; m_ifpc = 64'h0; m_valid = 1'b0; m_cnt = 32'h0;
            m_known = 1'b1;
        end else if (bus.Branch_Taken) begin
            m_pc = bus.Branch_Target & ~64'h3;
            m_instr = NOP; m_ifpc = 64'h0; m_valid = 1'b0;
        end else if (st) begin
            if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
        end else begin
            m_ifpc = m_pc; m_instr = bus.Instruction; m_pc = m_pc + 64'd4; m_valid = 1'b1;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (m_known) begin
            chk("pc_out", bus.PC_Out, m_pc);
            chk("if_id_pc", bus.IF_ID_PC_Out, m_ifpc);
            chk("if_id_instr", bus.IF_ID_Instruction, m_instr);
            chk("if_id_valid", bus.IF_ID_Valid, m_valid);
            chk("rs1", bus.IF_ID_rs1, m_instr[19:15]);
            chk("rs2", bus.IF_ID_rs2, m_instr[24:20]);
            chk("rd", bus.IF_ID_rd, m_instr[11:7]);
            chk("ins", bus.IF_ID_Ins, {m_instr[30], m_instr[14:12]});
            chk("stall", bus.Stall, model_stall());
            chk("flush", bus.Flush, bus.Branch_Taken);
            chk("stall_count", bus.Stall_Count, m_cnt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic bt, input logic [63:0] tgt, input logic mr,
                          input logic [4:0] rd, input logic [31:0] instr);
        bus.Branch_Taken  = bt;
        bus.Branch_Target = tgt;
        bus.ID_EX_MemRead = mr;
        bus.ID_EX_rd      = rd;
        bus.Instruction   = instr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, 64'h0, 1'b0, 5'd0, NOP);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] instr;
        reset = 1'b1;
        set_in(1'b0, 64'h0, 1'b0, 5'd0, NOP);

        // Reset state and straight-line fetch.
        do_reset();
        chk("rst_pc", bus.PC_Out, 64'h0);
        chk("rst_valid", bus.IF_ID_Valid, 1'b0);
        chk("rst_instr", bus.IF_ID_Instruction, NOP);
        chk("rst_ifpc", bus.IF_ID_PC_Out, 64'h0);
        chk("rst_cnt", bus.Stall_Count, 32'h0);
        set_in(1'b0, 64'h0, 1'b0, 5'd0, 32'h00A00093);
        tick();
        chk("seq_pc1", bus.PC_Out, 64'h4);
        chk("seq_ifpc1", bus.IF_ID_PC_Out, 64'h0);
        chk("seq_valid1", bus.IF_ID_Valid, 1'b1);
        chk("seq_instr1", bus.IF_ID_Instruction, 32'h00A00093);
        tick();
        chk("seq_pc2", bus.PC_Out, 64'h8);
        chk("seq_ifpc2", bus.IF_ID_PC_Out, 64'h4);
        tick();
        chk("seq_pc3", bus.PC_Out, 64'hC);
        chk("seq_ifpc3", bus.IF_ID_PC_Out, 64'h8);

        // Load-use hazard on rs2.
        do_reset();
        set_in(1'b0, 64'h0, 1'b0, 5'd0, 32'h002081B3);
        tick();
        set_in(1'b0, 64'h0, 1'b1, 5'd2, NOP);
        @(negedge clk);
        chk("lu_stall", bus.Stall, HAZ);
        chk("lu_rs1", bus.IF_ID_rs1, 5'd1);
        chk("lu_rs2", bus.IF_ID_rs2, 5'd2);
        chk("lu_rd", bus.IF_ID_rd, 5'd3);
        chk("lu_ins", bus.IF_ID_Ins, 4'h0);
        tick();
        chk("lu_pc", bus.PC_Out, HAZ ? 64'h4 : 64'h8);
        chk("lu_ifpc", bus.IF_ID_PC_Out, HAZ ? 64'h0 : 64'h4);
        chk("lu_instr", bus.IF_ID_Instruction, HAZ ? 32'h002081B3 : NOP);
        chk("lu_cnt", bus.Stall_Count, HAZ ? 32'h1 : 32'h0);

        // Load to x0 is never a hazard.
        do_reset();
        set_in(1'b0, 64'h0, 1'b0, 5'd0, 32'h002081B3);
        tick();
        set_in(1'b0, 64'h0, 1'b1, 5'd0, NOP);
        @(negedge clk);
        chk("x0_stall", bus.Stall, 1'b0);
        tick();
        chk("x0_pc", bus.PC_Out, 64'h8);
        chk("x0_ifpc", bus.IF_ID_PC_Out, 64'h4);
        chk("x0_cnt", bus.Stall_Count, 32'h0);

        // Branch redirect from PC 0x20 to unaligned 0x103.
        do_reset();
        set_in(1'b0, 64'h0, 1'b0, 5'd0, 32'h00A00093);
        for (int i = 0; i < 8; i++) tick();
        chk("br_pc_before", bus.PC_Out, 64'h20);
        set_in(1'b1, 64'h103, 1'b0, 5'd0, 32'h00A00093);
        @(negedge clk);
        chk("br_flush", bus.Flush, 1'b1);
        tick();
        chk("br_pc", bus.PC_Out, 64'h100);
        chk("br_instr", bus.IF_ID_Instruction, NOP);
        chk("br_valid", bus.IF_ID_Valid, 1'b0);
        chk("br_ifpc", bus.IF_ID_PC_Out, 64'h0);

        // Branch and hazard together, then PC wrap at the top of memory.
        do_reset();
        set_in(1'b0, 64'h0, 1'b0, 5'd0, 32'h002081B3);
        tick();
        set_in(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd2, NOP);
        @(negedge clk);
        chk("brhz_stall", bus.Stall, 1'b0);
        tick();
        chk("brhz_pc", bus.PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("brhz_cnt", bus.Stall_Count, 32'h0);
        set_in(1'b0, 64'h0, 1'b0, 5'd0, 32'h00A00093);
        tick();
        chk("wrap_pc", bus.PC_Out, 64'h0);
        chk("wrap_ifpc", bus.IF_ID_PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset asserted while a stall is pending.
        do_reset();
        set_in(1'b0, 64'h0, 1'b0, 5'd0, 32'h002081B3);
        tick();
        set_in(1'b0, 64'h0, 1'b1, 5'd1, NOP);
        tick();
        chk("rs_cnt_pre", bus.Stall_Count, HAZ ? 32'h1 : 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_stall", bus.Stall, 1'b0);
        tick();
        reset = 1'b0;
        chk("rs_pc", bus.PC_Out, 64'h0);
        chk("rs_cnt", bus.Stall_Count, 32'h0);
        chk("rs_valid", bus.IF_ID_Valid, 1'b0);
        set_in(1'b0, 64'h0, 1'b0, 5'd0, NOP);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.Branch_Taken  = ($urandom_range(0, 7) == 0);
            bus.Branch_Target = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0)
                bus.Branch_Target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            bus.ID_EX_MemRead = 1'($urandom_range(0, 1));
            bus.ID_EX_rd      = 5'($urandom_range(0, 3));
            instr = $urandom;
            instr[19:15] = 5'($urandom_range(0, 3));
            instr[24:20] = 5'($urandom_range(0, 3));
            bus.Instruction = instr;
            tick();
        end

        reset = 1'b0;
        set_in(1'b0, 64'h0, 1'b0, 5'd0, NOP);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
